// File: rtl/lot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lot_pkg
// Purpose  : Shared constants and types for the hourly parking-lot logger.
//            HOURS  - number of hour slots in one workday (log depth)
//            HOUR_W - width of the hour index
//            rush_state_t - rush-hour tracker states
// Revision : 1.0 - initial release
// ============================================================================
package lot_pkg;

    localparam int HOURS  = 8;
    localparam int HOUR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUSH = 2'd1,
        DONE = 2'd2
    } rush_state_t;

endpackage
`default_nettype wire

// File: rtl/lot_occupancy.sv
`default_nettype none
// ============================================================================
// Module   : lot_occupancy
// Purpose  : Accepts or rejects entry/exit pulses and keeps the registered
//            occupancy of the lot, saturating at CAPACITY.
// Ports    : clk        - system clock
//            reset      - synchronous, active-high
//            car_enter  - one-cycle entry pulse
//            car_exit   - one-cycle exit pulse
//            occupancy  - cars currently in the lot (registered)
//            occ_next   - occupancy value to be loaded on the next edge
//            full       - occupancy == CAPACITY
//            enter_ok   - an entry is accepted this cycle
// Revision : 1.0 - initial release
// ============================================================================
module lot_occupancy #(
    parameter int CAPACITY = 3,
    parameter int OCC_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_enter,
    input  logic             car_exit,
    output logic [OCC_W-1:0] occupancy,
    output logic [OCC_W-1:0] occ_next,
    output logic             full,
    output logic             enter_ok
);

    logic exit_ok;

    assign full     = (occupancy == OCC_W'(CAPACITY));
    assign enter_ok = car_enter && !full;
    assign exit_ok  = car_exit && (occupancy != '0);

    // A simultaneous accepted entry and exit cancel out; at the full or
    // empty boundary only one of them is accepted, so a single step results.
    always_comb begin
        occ_next = occupancy;
        if (enter_ok && !exit_ok) begin
            occ_next = occupancy + OCC_W'(1);
        end else if (!enter_ok && exit_ok) begin
            occ_next = occupancy - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hourly_lot_logger.sv
`default_nettype none
// ============================================================================
// Module   : hourly_lot_logger
// Purpose  : Tracks lot occupancy, counts accepted entries per hour, logs
//            each hour's count when the hour index changes, and records the
//            start/end hours of the day's rush (first fill, then empty).
// Ports    : clk          - system clock
//            reset        - synchronous, active-high
//            hour_in      - current hour from the upstream hour counter
//            car_enter    - one-cycle entry pulse
//            car_exit     - one-cycle exit pulse
//            rd_addr      - log read address
//            occupancy    - cars currently in lot
//            full         - occupancy == CAPACITY
//            rd_data      - log[rd_addr], one-cycle latency
//            day_done     - one-cycle pulse after the 7->0 hour wrap
//            rush_start   - hour the lot first became full
//            rush_end     - hour the lot emptied after the rush
//            rush_started - rush_start is valid
//            rush_ended   - rush_end is valid
// Revision : 1.0 - initial release
// ============================================================================
module hourly_lot_logger
    import lot_pkg::*;
#(
    parameter int CAPACITY = 3,
    parameter int OCC_W    = 2,
    parameter int ENTRY_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [HOUR_W-1:0]  hour_in,
    input  logic               car_enter,
    input  logic               car_exit,
    input  logic [HOUR_W-1:0]  rd_addr,
    output logic [OCC_W-1:0]   occupancy,
    output logic               full,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               day_done,
    output logic [HOUR_W-1:0]  rush_start,
    output logic [HOUR_W-1:0]  rush_end,
    output logic               rush_started,
    output logic               rush_ended
);

    logic [OCC_W-1:0]   occ_next;
    logic               enter_ok;
    logic [HOUR_W-1:0]  hour_q;
    logic               hour_change;
    logic               day_wrap;
    logic [ENTRY_W-1:0] entry_count;
    logic [ENTRY_W-1:0] count_plus;
    logic [ENTRY_W-1:0] log_mem [HOURS];

    rush_state_t        state;
    rush_state_t        state_next;
    logic               capture_start;
    logic               capture_end;

    lot_occupancy #(
        .CAPACITY (CAPACITY),
        .OCC_W    (OCC_W)
    ) u_occupancy (
        .clk       (clk),
        .reset     (reset),
        .car_enter (car_enter),
        .car_exit  (car_exit),
        .occupancy (occupancy),
        .occ_next  (occ_next),
        .full      (full),
        .enter_ok  (enter_ok)
    );

    assign hour_change = (hour_in != hour_q);
    assign day_wrap    = (hour_q == HOUR_W'(HOURS - 1)) && (hour_in == '0);

    // Count including this cycle's entry, holding at the all-ones ceiling.
    assign count_plus = (enter_ok && (entry_count != '1))
                      ? entry_count + ENTRY_W'(1)
                      : entry_count;

    // ------------------------------------------------------------------
    // Hour tracking, entry counter, log array and read port.
    // The read uses the pre-edge array contents, so a same-cycle write to
    // the read address returns the old value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hour_q      <= '0;
            entry_count <= '0;
            day_done    <= 1'b0;
            rd_data     <= '0;
            for (int i = 0; i < HOURS; i++) begin
                log_mem[i] <= '0;
            end
        end else begin
            hour_q   <= hour_in;
            day_done <= day_wrap;
            rd_data  <= log_mem[rd_addr];
            if (hour_change) begin
                // The closing hour absorbs this cycle's entry; the new hour
                // starts from zero so that entry is not counted twice.
                log_mem[hour_q] <= count_plus;
                entry_count     <= '0;
            end else begin
                entry_count <= count_plus;
            end
        end
    end

    // ------------------------------------------------------------------
    // Rush FSM: decisions use the occupancy about to be registered so the
    // captured hour is the one in which the filling/emptying event occurred.
    // A day wrap overrides any transition in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        capture_start = 1'b0;
        capture_end   = 1'b0;
        if (day_wrap) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (occ_next == OCC_W'(CAPACITY)) begin
                        state_next    = RUSH;
                        capture_start = 1'b1;
                    end
                end
                RUSH: begin
                    if (occ_next == '0) begin
                        state_next  = DONE;
                        capture_end = 1'b1;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || day_wrap) begin
            rush_start   <= '0;
            rush_end     <= '0;
            rush_started <= 1'b0;
            rush_ended   <= 1'b0;
        end else begin
            if (capture_start) begin
                rush_start   <= hour_q;
                rush_started <= 1'b1;
            end
            if (capture_end) begin
                rush_end   <= hour_q;
                rush_ended <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hourly_lot_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_hourly_lot_logger
// Purpose  : Self-checking bench for hourly_lot_logger. Stimulus drives one
//            cycle at a time on the falling edge and pushes the expected
//            post-edge outputs into a queue; a monitor pops and compares
//            just after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hourly_lot_logger;

    localparam int CAP  = 3;
    localparam int EMAX = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] hour_in = '0;
    logic       car_enter = 1'b0;
    logic       car_exit = 1'b0;
    logic [2:0] rd_addr = '0;
    logic [1:0] occupancy;
    logic       full;
    logic [3:0] rd_data;
    logic       day_done;
    logic [2:0] rush_start;
    logic [2:0] rush_end;
    logic       rush_started;
    logic       rush_ended;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int occ;
        int full;
        int rd;
        int dd;
        int rs;
        int re;
        int rsv;
        int rev;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: lot contents, hour bookkeeping and rush phase
    // (0 = waiting for full, 1 = waiting for empty, 2 = finished for the day).
    int m_occ, m_hq, m_cnt, m_phase, m_rs, m_re, m_rsv, m_rev;
    int m_log[8];

    hourly_lot_logger dut (
        .clk          (clk),
        .reset        (reset),
        .hour_in      (hour_in),
        .car_enter    (car_enter),
        .car_exit     (car_exit),
        .rd_addr      (rd_addr),
        .occupancy    (occupancy),
        .full         (full),
        .rd_data      (rd_data),
        .day_done     (day_done),
        .rush_start   (rush_start),
        .rush_end     (rush_end),
        .rush_started (rush_started),
        .rush_ended   (rush_ended)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Apply one cycle of stimulus and advance the model by one clock.
    task automatic step(input bit r, input int h, input bit en, input bit ex, input int a);
        exp_t e;
        int   nocc;
        int   ncnt;
        bit   in_ok;
        bit   out_ok;
        bit   wrap;
        @(negedge clk);
        reset     = r;
        hour_in   = 3'(h);
        car_enter = en;
        car_exit  = ex;
        rd_addr   = 3'(a);
        if (r) begin
            m_occ = 0; m_hq = 0; m_cnt = 0; m_phase = 0;
            m_rs = 0; m_re = 0; m_rsv = 0; m_rev = 0;
            foreach (m_log[i]) m_log[i] = 0;
            e.rd = 0;
            e.dd = 0;
        end else begin
            e.rd   = m_log[a];
            in_ok  = en && (m_occ < CAP);
            out_ok = ex && (m_occ > 0);
            nocc   = m_occ + int'(in_ok) - int'(out_ok);
            ncnt   = (m_cnt + int'(in_ok) > EMAX) ? EMAX : m_cnt + int'(in_ok);
            wrap   = (m_hq == 7) && (h == 0);
            if (h != m_hq) begin
                m_log[m_hq] = ncnt;
                m_cnt = 0;
            end else begin
                m_cnt = ncnt;
            end
            e.dd = wrap;
            if (wrap) begin
                m_phase = 0; m_rs = 0; m_re = 0; m_rsv = 0; m_rev = 0;
            end else if (m_phase == 0 && nocc == CAP) begin
                m_phase = 1; m_rs = m_hq; m_rsv = 1;
            end else if (m_phase == 1 && nocc == 0) begin
                m_phase = 2; m_re = m_hq; m_rev = 1;
            end
            m_occ = nocc;
            m_hq  = h;
        end
        e.occ  = m_occ;
        e.full = (m_occ == CAP);
        e.rs   = m_rs;
        e.re   = m_re;
        e.rsv  = m_rsv;
        e.rev  = m_rev;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every output one time unit after each rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("occupancy",    int'(occupancy),    e.occ);
                check("full",         int'(full),         e.full);
                check("rd_data",      int'(rd_data),      e.rd);
                check("day_done",     int'(day_done),     e.dd);
                check("rush_start",   int'(rush_start),   e.rs);
                check("rush_end",     int'(rush_end),     e.re);
                check("rush_started", int'(rush_started), e.rsv);
                check("rush_ended",   int'(rush_ended),   e.rev);
            end
        end
    end

    initial begin : stimulus
        int h;
        int drain;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Fill at hour 0, 4th entry rejected; then boundary enter+exit cases.
        repeat (4) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        repeat (2) step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        // Two entries in hour 1, then change to hour 2 and read log[1].
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 2, 0, 1, 1);
        step(0, 2, 0, 0, 1);
        step(0, 2, 0, 0, 1);
        // 17 entries in hour 2 with exits between: logged value saturates.
        repeat (17) begin
            step(0, 2, 1, 0, 2);
            step(0, 2, 0, 1, 2);
        end
        step(0, 3, 0, 0, 2);
        step(0, 3, 0, 0, 2);
        step(0, 3, 0, 0, 2);
        // Walk to the day wrap to clear the rush seen at hour 0.
        for (int k = 4; k <= 7; k++) step(0, k, 0, 0, 7);
        step(0, 0, 0, 0, 7);
        step(0, 0, 0, 0, 7);
        step(0, 0, 0, 0, 7);
        // Rush: fill in hour 2, empty in hour 5, refill in hour 6.
        step(0, 1, 0, 0, 0);
        repeat (3) step(0, 2, 1, 0, 2);
        step(0, 3, 0, 0, 2);
        step(0, 4, 0, 0, 3);
        repeat (3) step(0, 5, 0, 1, 4);
        repeat (3) step(0, 6, 1, 0, 5);
        step(0, 7, 1, 1, 6);
        step(0, 0, 1, 0, 6);
        step(0, 0, 0, 0, 7);
        // Reset in the middle of a rush.
        step(0, 0, 1, 0, 7);
        step(0, 0, 1, 0, 7);
        step(1, 0, 1, 0, 7);
        step(0, 0, 0, 0, 0);
        // Randomized traffic with occasional hour steps, jumps and resets.
        h = 0;
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 8)       h = (h + 1) % 8;
            else if (sel < 10) h = int'($urandom_range(0, 7));
            step(($urandom_range(0, 399) == 0),
                 h,
                 ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 40),
                 int'($urandom_range(0, 7)));
        end
        step(0, h, 0, 0, 0);
        drain = 0;
        while (exp_q.size() > 0 && drain < 100) begin
            @(posedge clk);
            drain++;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
